// File: rtl/mem_pkg.sv
// Shared opcode, size and state definitions for the MEM-stage access unit.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  function automatic logic op_is_load(input logic [5:0] o);
    return o inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic op_is_store(input logic [5:0] o);
    return o inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic op_legal(input logic [5:0] o);
    return op_is_load(o) || op_is_store(o);
  endfunction

  // Access size lives in the low two opcode bits for every legal op.
  function automatic size_t op_size(input logic [5:0] o);
    case (o[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic op_aligned(input logic [5:0] o, input logic [1:0] off);
    case (op_size(o))
      SZ_B:    return 1'b1;
      SZ_H:    return ~off[0];
      default: return off == 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Byte-lane steering: store-side enables/replicated data and load-side extraction/extension.
module mau_lane
  import mem_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] ld_c
);

  logic [31:0] rsh;

  // Bring the addressed lane down to bit 0 for extraction.
  assign rsh = rdata >> {off, 3'b000};

  // Lane enables, write replication and load extension by access size; op[2] marks unsigned loads.
  always_comb begin
    be_c    = '0;
    wdata_c = '0;
    ld_c    = '0;
    case (op_size(op))
      SZ_B: begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{st_data[7:0]}};
        ld_c    = op[2] ? {24'h0, rsh[7:0]} : {{24{rsh[7]}}, rsh[7:0]};
      end
      SZ_H: begin
        be_c    = 4'b0011 << off;
        wdata_c = {2{st_data[15:0]}};
        ld_c    = op[2] ? {16'h0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = st_data;
        ld_c    = rsh;
      end
    endcase
    if (!op_is_store(op)) wdata_c = '0;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: decode, align check, memory handshake with timeout, load extension.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [5:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       st_data,
  output logic              req_ready,
  output logic [31:0]       ld_data,
  output logic              done,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = 8;

  state_t           state;
  logic [5:0]       op_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [5:0]       lane_op;
  logic [1:0]       lane_off;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [31:0]      ld_c;
  logic             legal_c;
  logic             aligned_c;

  // The lane unit sees the incoming request while idle and the latched access afterwards.
  assign lane_op   = (state == ST_IDLE) ? op : op_q;
  assign lane_off  = (state == ST_IDLE) ? addr[1:0] : off_q;
  assign legal_c   = op_legal(op);
  assign aligned_c = op_aligned(op, addr[1:0]);
  assign cnt_nxt   = cnt + CNT_W'(1);

  mau_lane u_lane (
    .op      (lane_op),
    .off     (lane_off),
    .st_data (st_data),
    .rdata   (mem_rdata),
    .be_c    (be_c),
    .wdata_c (wdata_c),
    .ld_c    (ld_c)
  );

  // Access FSM with registered handshake, status pulses and load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      off_q     <= '0;
      cnt       <= '0;
      req_ready <= 1'b1;
      ld_data   <= '0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && legal_c) begin
            if (!aligned_c) begin
              misalign <= 1'b1;
            end else begin
              op_q      <= op;
              off_q     <= addr[1:0];
              cnt       <= '0;
              mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              mem_we    <= op_is_store(op);
              mem_be    <= be_c;
              mem_wdata <= wdata_c;
              mem_req   <= 1'b1;
              req_ready <= 1'b0;
              state     <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // An ack arriving on the timeout cycle still completes the access.
          if (mem_ack) begin
            if (op_is_load(op_q)) ld_data <= ld_c;
            done      <= 1'b1;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            state     <= ST_RESP;
          end else if (cnt_nxt == CNT_W'(TIMEOUT)) begin
            bus_err   <= 1'b1;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        ST_RESP: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
